// File: rtl/uart_rx_msg.sv
// -----------------------------------------------------------------------------
// uart_rx_msg
//
// Command-frame parser that sits between the byte-level UART receiver and the
// CORDIC core / uart_tx_msg path. Received bytes are assembled into frames:
//
//   SINGLE (0x01): SOF, CMD, NB theta bytes, CRC
//   RANGE  (0x02): SOF, CMD, BURST, NB start bytes, NB step bytes, CRC
//
// Payload bytes arrive MSB first, NB = TW/8. A good frame produces a one-cycle
// o_cmd_valid pulse together with freshly updated command outputs. A bad,
// timed-out or refused (busy) frame produces a one-cycle o_rx_msg_err pulse and
// leaves the command outputs untouched.
//
// Optional feature macro: UART_RX_MSG_CRC_EN
//   defined   : CRC-8 (poly 0x07, init 0x00, MSB first, no final XOR) over
//               CMD..last payload byte is computed and checked.
//   undefined : no CRC logic; the CRC byte is consumed and any value accepted.
//
// Parameters:
//   SOF_BYTE        start-of-frame marker
//   TIMEOUT_CYCLES  max idle i_clk cycles between bytes inside a frame
//   TW              operand width in bits (multiple of 8)
//
// Ports:
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_rx_byte        byte from the UART receiver
//   i_rx_byte_valid  one-cycle strobe qualifying i_rx_byte
//   i_busy           downstream still processing the previous command
//   o_cmd_reg        decoded command byte
//   o_cmd_valid      one-cycle pulse, command outputs valid
//   o_burst_cnt      number of results requested
//   o_theta_start    first angle operand
//   o_theta_step     angle increment (0 for SINGLE)
//   o_rx_msg_err     one-cycle pulse marking a dropped or bad frame
// -----------------------------------------------------------------------------
module uart_rx_msg #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         TW             = 48
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_rx_byte_valid,
  input  logic          i_busy,
  output logic [7:0]    o_cmd_reg,
  output logic          o_cmd_valid,
  output logic [7:0]    o_burst_cnt,
  output logic [TW-1:0] o_theta_start,
  output logic [TW-1:0] o_theta_step,
  output logic          o_rx_msg_err
);

  localparam int NB  = TW / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_SINGLE = 8'h01;
  localparam logic [7:0] CMD_RANGE  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_BURST,
    S_START,
    S_STEP,
    S_CHK
  } state_t;

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic [7:0]     cmd_r;
  logic [7:0]     burst_r;
  logic           is_range;
  logic [TW-1:0]  start_sr;
  logic [TW-1:0]  step_sr;
  logic           crc_ok;

`ifdef UART_RX_MSG_CRC_EN
  logic [7:0] crc_r;
  logic [7:0] crc_nxt;

  // Byte-wise CRC-8, MSB first: fold the byte in, then eight shift/xor steps.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_nxt = crc8_byte(crc_r, i_rx_byte);
  assign crc_ok  = (i_rx_byte == crc_r);

  // Running CRC over CMD..last payload byte. Cleared on SOF so every frame
  // starts from the 0x00 init value; SOF and the CRC byte itself are excluded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_r <= 8'h00;
    end else if (i_rx_byte_valid) begin
      case (state)
        S_IDLE:  if (i_rx_byte == SOF_BYTE) crc_r <= 8'h00;
        S_CMD,
        S_BURST,
        S_START,
        S_STEP:  crc_r <= crc_nxt;
        default: crc_r <= crc_r;
      endcase
    end
  end
`else
  // Without the CRC feature the check byte is accepted unconditionally.
  assign crc_ok = 1'b1;
`endif

  // Frame FSM. Pulses default low every cycle so they last exactly one cycle.
  // A timeout can only occur in a cycle with no byte strobe, so the byte path
  // and the timeout path never compete. Every error returns to IDLE; the
  // deciding byte is consumed in that same cycle, so nothing is left over.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      cmd_r         <= 8'h00;
      burst_r       <= 8'h00;
      is_range      <= 1'b0;
      start_sr      <= '0;
      step_sr       <= '0;
      o_cmd_reg     <= 8'h00;
      o_cmd_valid   <= 1'b0;
      o_burst_cnt   <= 8'h00;
      o_theta_start <= '0;
      o_theta_step  <= '0;
      o_rx_msg_err  <= 1'b0;
    end else begin
      o_cmd_valid  <= 1'b0;
      o_rx_msg_err <= 1'b0;

      if (!i_rx_byte_valid) begin
        if (state != S_IDLE) begin
          if (tmo_cnt == TMO_LAST) begin
            o_rx_msg_err <= 1'b1;
            state        <= S_IDLE;
            tmo_cnt      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      end else begin
        tmo_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (i_rx_byte == SOF_BYTE) begin
              byte_cnt <= '0;
              state    <= S_CMD;
            end
          end

          S_CMD: begin
            cmd_r <= i_rx_byte;
            if (i_rx_byte == CMD_SINGLE) begin
              burst_r  <= 8'd1;
              step_sr  <= '0;
              is_range <= 1'b0;
              state    <= S_START;
            end else if (i_rx_byte == CMD_RANGE) begin
              is_range <= 1'b1;
              state    <= S_BURST;
            end else begin
              o_rx_msg_err <= 1'b1;
              state        <= S_IDLE;
            end
          end

          S_BURST: begin
            if (i_rx_byte == 8'h00) begin
              o_rx_msg_err <= 1'b1;
              state        <= S_IDLE;
            end else begin
              burst_r <= i_rx_byte;
              state   <= S_START;
            end
          end

          S_START: begin
            start_sr <= {start_sr[TW-9:0], i_rx_byte};
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= is_range ? S_STEP : S_CHK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end

          S_STEP: begin
            step_sr <= {step_sr[TW-9:0], i_rx_byte};
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= S_CHK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end

          S_CHK: begin
            // Outputs change only here, together with the valid pulse.
            if (crc_ok && !i_busy) begin
              o_cmd_valid   <= 1'b1;
              o_cmd_reg     <= cmd_r;
              o_burst_cnt   <= burst_r;
              o_theta_start <= start_sr;
              o_theta_step  <= step_sr;
            end else begin
              o_rx_msg_err <= 1'b1;
            end
            state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_msg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_msg
//
// Self-checking bench for uart_rx_msg. Frames are built from field values, the
// CRC is obtained by polynomial long division of the augmented message, and the
// expected outputs are held in a small model of the last accepted command.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// following the rising edge that consumed each byte.
// -----------------------------------------------------------------------------
module tb_uart_rx_msg;

  localparam int TW  = 48;
  localparam int NB  = TW / 8;
  localparam int TMO = 100;

`ifdef UART_RX_MSG_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          busy;
  logic [7:0]    cmd_reg;
  logic          cmd_valid;
  logic [7:0]    burst_cnt;
  logic [TW-1:0] theta_start;
  logic [TW-1:0] theta_step;
  logic          rx_msg_err;

  uart_rx_msg #(
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (TMO),
    .TW             (TW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rx_byte       (rx_byte),
    .i_rx_byte_valid (rx_valid),
    .i_busy          (busy),
    .o_cmd_reg       (cmd_reg),
    .o_cmd_valid     (cmd_valid),
    .o_burst_cnt     (burst_cnt),
    .o_theta_start   (theta_start),
    .o_theta_step    (theta_step),
    .o_rx_msg_err    (rx_msg_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int   valid_seen;
  int   err_seen;
  int   both_seen;
  logic last_valid;
  logic last_err;

  logic [7:0] frame [$];

  // Model of the held command outputs.
  logic [7:0]    exp_cmd;
  logic [7:0]    exp_burst;
  logic [TW-1:0] exp_start;
  logic [TW-1:0] exp_step;

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crcModel(input logic [7:0] msg [$]);
    logic [8:0] r;
    logic       bitv;
    r = '0;
    for (int i = 0; i <= msg.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        bitv = (i < msg.size()) ? msg[i][b] : 1'b0;
        r = {r[7:0], bitv};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sampleCycle();
    if (cmd_valid === 1'b1) valid_seen++;
    if (rx_msg_err === 1'b1) err_seen++;
    if (cmd_valid === 1'b1 && rx_msg_err === 1'b1) both_seen++;
    last_valid = cmd_valid;
    last_err   = rx_msg_err;
  endtask

  task automatic clearSeen();
    valid_seen = 0;
    err_seen   = 0;
    both_seen  = 0;
    last_valid = 1'b0;
    last_err   = 1'b0;
  endtask

  // Drive one byte strobe for one cycle, then sample the resulting outputs.
  task automatic applyStimulus(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    sampleCycle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      sampleCycle();
    end
  endtask

  task automatic modelReset();
    exp_cmd   = 8'h00;
    exp_burst = 8'h00;
    exp_start = '0;
    exp_step  = '0;
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_cmd_reg"},     64'(cmd_reg),     64'(exp_cmd));
    checkOutput({tag, "_burst_cnt"},   64'(burst_cnt),   64'(exp_burst));
    checkOutput({tag, "_theta_start"}, 64'(theta_start), 64'(exp_start));
    checkOutput({tag, "_theta_step"},  64'(theta_step),  64'(exp_step));
  endtask

  task automatic checkFrame(input string tag, input bit exp_valid);
    checkOutput({tag, "_valid_latency"}, 64'(last_valid), 64'(exp_valid));
    checkOutput({tag, "_err_latency"},   64'(last_err),   64'(!exp_valid));
    checkOutput({tag, "_valid_count"},   64'(valid_seen), 64'(exp_valid));
    checkOutput({tag, "_err_count"},     64'(err_seen),   64'(!exp_valid));
    checkOutput({tag, "_both_high"},     64'(both_seen),  64'd0);
    checkHeld(tag);
  endtask

  task automatic buildFrame(input logic [7:0] cmd, input logic [7:0] burst,
                            input logic [TW-1:0] start, input logic [TW-1:0] step);
    logic [7:0] body [$];
    body = {};
    body.push_back(cmd);
    if (cmd == 8'h02) body.push_back(burst);
    for (int i = NB - 1; i >= 0; i--) body.push_back(start[i*8 +: 8]);
    if (cmd == 8'h02) begin
      for (int i = NB - 1; i >= 0; i--) body.push_back(step[i*8 +: 8]);
    end
    frame = {};
    frame.push_back(8'hA5);
    foreach (body[i]) frame.push_back(body[i]);
    frame.push_back(crcModel(body));
  endtask

  // Send a complete frame, optionally busy or with a corrupted CRC byte, and
  // check the outcome against the model.
  task automatic runFrame(input string tag, input logic [7:0] cmd, input logic [7:0] burst,
                          input logic [TW-1:0] start, input logic [TW-1:0] step,
                          input bit busy_last, input bit corrupt, input int gap);
    bit exp_valid;
    clearSeen();
    idleCycles(gap);
    buildFrame(cmd, burst, start, step);
    if (corrupt) frame[frame.size()-1] = frame[frame.size()-1] ^ 8'h01;
    for (int i = 0; i < frame.size(); i++) begin
      if (i == frame.size() - 1) busy = busy_last;
      applyStimulus(frame[i]);
    end
    busy = 1'b0;
    exp_valid = !busy_last && !(corrupt && CRC_EN);
    if (exp_valid) begin
      exp_cmd   = cmd;
      exp_burst = (cmd == 8'h01) ? 8'd1 : burst;
      exp_start = start;
      exp_step  = (cmd == 8'h01) ? '0 : step;
    end
    checkFrame(tag, exp_valid);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            first_err;
    bit            r_range;
    bit            r_busy;
    bit            r_corrupt;
    logic [7:0]    r_burst;
    logic [TW-1:0] r_start;
    logic [TW-1:0] r_step;

    rst      = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    busy     = 1'b0;
    modelReset();
    clearSeen();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_err",       64'(rx_msg_err), 64'd0);
    checkHeld("reset");

    // Garbage before SOF is ignored
    clearSeen();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h33);
    checkOutput("garbage_valid", 64'(valid_seen), 64'd0);
    checkOutput("garbage_err",   64'(err_seen),   64'd0);

    // Directed SINGLE and RANGE frames
    runFrame("single", 8'h01, 8'h00, 48'h0000_0000_1000, 48'h0, 1'b0, 1'b0, 0);
    runFrame("range",  8'h02, 8'h04, 48'h0000_0000_0100, 48'h0000_0000_0020, 1'b0, 1'b0, 0);

    // Corrupted CRC
    runFrame("single_badcrc", 8'h01, 8'h00, 48'h0000_0000_1000, 48'h0, 1'b0, 1'b1, 2);

    // Unknown command
    clearSeen();
    applyStimulus(8'hA5);
    applyStimulus(8'h07);
    checkFrame("bad_cmd", 1'b0);

    // Zero burst
    clearSeen();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    checkFrame("zero_burst", 1'b0);

    runFrame("after_err", 8'h02, 8'h09, 48'h1234_5678_9ABC, 48'h0000_A5A5_0001, 1'b0, 1'b0, 0);

    // Timeout inside a frame
    clearSeen();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    first_err = -1;
    for (int k = 1; k <= TMO + 5; k++) begin
      @(negedge clk);
      sampleCycle();
      if (rx_msg_err === 1'b1 && first_err < 0) first_err = k;
    end
    checkOutput("timeout_err_count",   64'(err_seen),   64'd1);
    checkOutput("timeout_valid_count", 64'(valid_seen), 64'd0);
    checkOutput("timeout_window", 64'(first_err >= TMO - 1 && first_err <= TMO + 1), 64'd1);
    checkHeld("timeout");

    // Reset in the middle of a frame
    clearSeen();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst = 1'b1;
    idleCycles(2);
    rst = 1'b0;
    idleCycles(2);
    modelReset();
    checkOutput("midreset_valid", 64'(valid_seen), 64'd0);
    checkOutput("midreset_err",   64'(err_seen),   64'd0);
    checkHeld("midreset");
    runFrame("after_reset", 8'h01, 8'h00, 48'hFEDC_BA98_7654, 48'h0, 1'b0, 1'b0, 0);

    // Busy when the CRC byte arrives
    runFrame("busy", 8'h01, 8'h00, 48'h0000_0000_0777, 48'h0, 1'b1, 1'b0, 1);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      r_range   = 1'($urandom_range(0, 1));
      r_burst   = 8'($urandom_range(1, 255));
      r_start   = {16'($urandom), 32'($urandom)};
      r_step    = {16'($urandom), 32'($urandom)};
      r_busy    = ($urandom_range(0, 3) == 0);
      r_corrupt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) r_start[15:8] = 8'hA5;
      runFrame($sformatf("rand%0d", n), r_range ? 8'h02 : 8'h01, r_burst,
               r_start, r_step, r_busy, r_corrupt, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
